// File: rtl/pwm_shadow_loader.sv
// Shadow period/compare buffer for one PWM channel.
// Commits the buffered pair to the active registers on a qualifying mask event.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_shadow_loader #(
    parameter int WIDTH      = `PWMCOUNT_WIDTH,
    parameter int RST_PERIOD = 1000,
    parameter int SKIP_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              maskevent,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WIDTH-1:0]  wr_period,
    input  logic [WIDTH-1:0]  wr_compare,
    input  logic [SKIP_W-1:0] skip,
    input  logic              flush,
    output logic [WIDTH-1:0]  period_act,
    output logic [WIDTH-1:0]  compare_act,
    output logic              pending,
    output logic              load_done
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  shadow_period;
    logic [WIDTH-1:0]  shadow_compare;
    logic [SKIP_W-1:0] skip_cnt;

    logic              accept;
    logic [WIDTH-1:0]  clamped_compare;

    assign wr_ready = (state == IDLE) && !flush;
    assign pending  = (state == PENDING);
    assign accept   = wr_valid && wr_ready;

    // Compare above period would never match the carrier; pin it to period.
    assign clamped_compare = (wr_compare > wr_period) ? wr_period : wr_compare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            shadow_period  <= '0;
            shadow_compare <= '0;
            skip_cnt       <= '0;
            period_act     <= WIDTH'(RST_PERIOD);
            compare_act    <= '0;
            load_done      <= 1'b0;
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        shadow_period  <= wr_period;
                        shadow_compare <= clamped_compare;
                        skip_cnt       <= skip;
                        state          <= PENDING;
                    end
                end
                PENDING: begin
                    // Flush wins over a coincident mask event.
                    if (flush) begin
                        state <= IDLE;
                    end else if (maskevent) begin
                        if (skip_cnt == '0) begin
                            period_act  <= shadow_period;
                            compare_act <= shadow_compare;
                            load_done   <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            skip_cnt <= skip_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_shadow_loader.sv
// Directed vector bench for pwm_shadow_loader.
// Table-driven cycle vectors plus hand sequences for skip-max and async reset.
`timescale 1ns/1ps

module tb_pwm_shadow_loader;

    logic        clk;
    logic        reset;
    logic        maskevent;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_period;
    logic [15:0] wr_compare;
    logic [3:0]  skip;
    logic        flush;
    logic [15:0] period_act;
    logic [15:0] compare_act;
    logic        pending;
    logic        load_done;

    int total = 0;
    int bad   = 0;

    pwm_shadow_loader #(
        .WIDTH(16),
        .RST_PERIOD(1000),
        .SKIP_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .maskevent(maskevent),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_period(wr_period),
        .wr_compare(wr_compare),
        .skip(skip),
        .flush(flush),
        .period_act(period_act),
        .compare_act(compare_act),
        .pending(pending),
        .load_done(load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  s;
        logic        me;
        logic        fl;
        logic [15:0] epa;
        logic [15:0] eca;
        logic        epend;
        logic        eld;
        logic        erdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, int p, int c, int s, logic me,
                                logic fl, int epa, int eca, logic epend,
                                logic eld, logic erdy);
        vec_t r;
        r.v = v; r.p = 16'(p); r.c = 16'(c); r.s = 4'(s);
        r.me = me; r.fl = fl;
        r.epa = 16'(epa); r.eca = 16'(eca);
        r.epend = epend; r.eld = eld; r.erdy = erdy;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int epa, int eca, logic epend,
                           logic eld, logic erdy);
        chk({tag, " period_act"}, 32'(period_act), 32'(epa));
        chk({tag, " compare_act"}, 32'(compare_act), 32'(eca));
        chk({tag, " pending"}, 32'(pending), 32'(epend));
        chk({tag, " load_done"}, 32'(load_done), 32'(eld));
        chk({tag, " wr_ready"}, 32'(wr_ready), 32'(erdy));
    endtask

    task automatic drive(logic v, int p, int c, int s, logic me, logic fl);
        @(negedge clk);
        wr_valid   = v;
        wr_period  = 16'(p);
        wr_compare = 16'(c);
        skip       = 4'(s);
        maskevent  = me;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        maskevent = 1'b0; wr_valid = 1'b0; flush = 1'b0;
        wr_period = '0; wr_compare = '0; skip = '0;

        // v  p    c    s me fl | pa  ca  pend ld rdy
        // basic commit, skip=0, event 3 cycles after accept
        tbl.push_back(mk(1, 500, 200, 0, 0, 0, 1000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 500, 200, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 500, 200, 0, 0, 1));
        // skip=2 with clamp 400 -> 300
        tbl.push_back(mk(1, 300, 400, 2, 0, 0, 500, 200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 500, 200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 500, 200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 500, 200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 500, 200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 300, 300, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 300, 300, 0, 0, 1));
        // event on the accept edge is not counted
        tbl.push_back(mk(1, 600, 100, 0, 1, 0, 300, 300, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 300, 300, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 600, 100, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 600, 100, 0, 0, 1));
        // held maskevent, skip=2, compare == period kept
        tbl.push_back(mk(1, 700, 700, 2, 0, 0, 600, 100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 600, 100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 600, 100, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 700, 700, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 700, 700, 0, 0, 1));
        // flush beats simultaneous maskevent
        tbl.push_back(mk(1, 800, 50, 0, 0, 0, 700, 700, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 700, 700, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 700, 700, 0, 0, 1));
        // wr_valid held during PENDING taken after return to IDLE
        tbl.push_back(mk(1, 900, 10, 1, 0, 0, 700, 700, 1, 0, 0));
        tbl.push_back(mk(1, 400, 400, 0, 1, 0, 700, 700, 1, 0, 0));
        tbl.push_back(mk(1, 400, 400, 0, 1, 0, 900, 10, 0, 1, 1));
        tbl.push_back(mk(1, 400, 400, 0, 0, 0, 900, 10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 400, 400, 0, 1, 1));
        // flush in IDLE blocks a write for that cycle only
        tbl.push_back(mk(1, 50, 20, 0, 0, 1, 400, 400, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 400, 400, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1000, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_reset", 1000, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, int'(tbl[i].p), int'(tbl[i].c), int'(tbl[i].s),
                  tbl[i].me, tbl[i].fl);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].epa),
                    int'(tbl[i].eca), tbl[i].epend, tbl[i].eld, tbl[i].erdy);
        end

        // skip at max counts 15 events down, commits on the 16th
        drive(1, 16'h8000, 16'hFFFF, 15, 0, 0);
        chk_all("smax_acc", 400, 400, 1, 0, 0);
        for (int k = 0; k < 15; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk_all($sformatf("smax_ev%0d", k), 400, 400, 1, 0, 0);
        end
        drive(0, 0, 0, 0, 1, 0);
        chk_all("smax_commit", 16'h8000, 16'h8000, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk_all("smax_after", 16'h8000, 16'h8000, 0, 0, 1);

        // async reset while pending with skip_cnt=1
        drive(1, 123, 45, 1, 0, 0);
        chk_all("rst_acc", 16'h8000, 16'h8000, 1, 0, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst_async", 1000, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 0);
            chk_all($sformatf("rst_rel%0d", k), 1000, 0, 0, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_shadow_loader.md
# pwm_shadow_loader

Consumer of the PWM mask-event strobe: holds a software-written period/compare pair in a shadow buffer and commits it to the active registers that drive the carrier and comparator, but only on a qualifying mask event. This keeps duty and period updates glitch-free at carrier minimum or maximum. It sits between the register-file write path and the carrier/compare datapath of each PWM channel. An event-skip counter lets software defer the commit by N mask events.

## Interface
Parameters:
- WIDTH, default `PWMCOUNT_WIDTH (16): width of period/compare values.
- RST_PERIOD, default 1000: reset value of period_act.
- SKIP_W, default 4: width of the skip count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- maskevent  in  1  registered mask-event strobe (high one or more cycles).
- wr_valid  in  1  new shadow pair offered.
- wr_ready  out  1  shadow buffer free; a write is accepted when wr_valid & wr_ready.
- wr_period  in  WIDTH  new period.
- wr_compare  in  WIDTH  new compare.
- skip  in  SKIP_W  number of qualifying mask events to ignore before committing; sampled at accept.
- flush  in  1  cancel a pending update.
- period_act  out  WIDTH  active period.
- compare_act  out  WIDTH  active compare.
- pending  out  1  a shadow pair is waiting for commit.
- load_done  out  1  one-cycle pulse on the cycle after a commit.

## Operation
- Reset values: period_act=RST_PERIOD, compare_act=0, pending=0, load_done=0, state=IDLE, so wr_ready=1.
- The FSM has two states: IDLE and PENDING.
- wr_ready = (state==IDLE) & ~flush. It is combinational from state and flush only.
- IDLE, accepting a write (wr_valid & wr_ready):
  - shadow_period <= wr_period.
  - shadow_compare <= min(wr_compare, wr_period); compare is clamped to period.
  - skip_cnt <= skip.
  - Go to PENDING.
- IDLE: maskevent is ignored.
- PENDING, maskevent=1 and skip_cnt==0:
  - period_act <= shadow_period, compare_act <= shadow_compare.
  - load_done <= 1.
  - Go to IDLE.
- PENDING, maskevent=1 and skip_cnt!=0: skip_cnt <= skip_cnt-1; stay in PENDING.
- Event counting: each clock cycle with maskevent high counts as one event. A strobe held high for k cycles counts k events.
- PENDING, flush=1: go to IDLE. The shadow is discarded and there is no commit. Flush has priority over a simultaneous maskevent.
- IDLE, flush=1: no effect, except that wr_ready is forced low so no write is accepted in that cycle.
- pending = (state==PENDING), combinational.
- Writes arriving while PENDING are not accepted (wr_ready=0). The source must hold wr_valid and its data until accepted.
- The active registers change only on a commit or on reset.
- All arithmetic is unsigned. The clamp compares full WIDTH values.

## Timing
- Accept at edge n; pending=1 from cycle n+1.
- A maskevent sampled at edge m counts only if the FSM is already in PENDING at edge m.
- A maskevent on the same edge as the accept is not counted.
- Commit at edge m: period_act and compare_act are new from cycle m+1. load_done is high for exactly cycle m+1. wr_ready=1 in cycle m+1, so back-to-back updates are possible.
- Latency from accept to commit: first qualifying event strictly after accept, plus skip further events.
- Reset asserted mid-PENDING: outputs return to reset values immediately (asynchronous). The shadow is lost and load_done stays low.
- skip at its maximum value (2^SKIP_W−1) must wrap-free count down to 0. No modular wrap is allowed.

## Test plan
- Reset, then check outputs: period_act=1000, compare_act=0, wr_ready=1, pending=0, load_done=0.
- Write period=500, compare=200, skip=0; maskevent 3 cycles later → commit on that edge, period_act=500 and compare_act=200 next cycle, one load_done pulse.
- Write period=300, compare=400, skip=2; pulse maskevent 3 times → first two ignored, commit on the third, compare_act=300 (clamped).
- Write with maskevent high on the accept edge, then maskevent 2 cycles later → commit only on the second event. With maskevent held 3 cycles and skip=2 → commit on the third held cycle.
- Pending write, then flush and maskevent on the same cycle → no commit, pending=0, actives unchanged. A wr_valid held during PENDING is accepted only after return to IDLE.
- Assert reset while PENDING with skip_cnt=1 → actives at reset values asynchronously, no load_done after release.
